// File: rtl/pulse_width_adc_pkg.sv
// Shared definitions for the pulse-width converter: FSM encoding and default sizing.
package pulse_width_adc_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACK       = 2'd1,
        WAIT_RISE = 2'd2,
        MEAS      = 2'd3
    } state_e;

    localparam int W_DEF       = 8;
    localparam int TIMEOUT_DEF = 1000;

    // Keeps the timeout counter at least one bit wide for TIMEOUT=1.
    function automatic int tcnt_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/pulse_width_adc_sat_counter.sv
// W-bit up-counter that can be loaded with 1, incremented with saturation, or held.
module sat_counter
    import pulse_width_adc_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         i_clock,
    input  logic         i_reset_n,
    input  logic         i_load1,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt <= '0;
        end else if (i_load1) begin
            r_cnt <= W'(1);
        end else if (i_inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pulse_width_adc.sv
// soc/eoc converter that returns the high-time of `in`, in clock cycles, as x.
module pulse_width_adc
    import pulse_width_adc_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic         clock,
    input  logic         reset_,
    input  logic         soc,
    input  logic         in,
    output logic         eoc,
    output logic [W-1:0] x
);

    localparam int            TW    = tcnt_width(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    state_e        r_state;
    state_e        w_state_nxt;
    logic          r_in_prev;
    logic          r_eoc;
    logic [TW-1:0] r_tcnt;
    logic [W-1:0]  r_x;
    logic [W-1:0]  w_cnt;

    logic w_rise;
    logic w_tlast;
    logic w_load1;
    logic w_inc;
    logic w_tclr;
    logic w_tinc;
    logic w_x_zero;
    logic w_x_cnt;

    assign w_rise  = in & ~r_in_prev;
    assign w_tlast = (r_tcnt == TLAST);

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A rise on the timeout edge takes priority, so measurement still starts.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (soc) w_state_nxt = ACK;
            ACK:       if (!soc) w_state_nxt = WAIT_RISE;
            WAIT_RISE: begin
                if (w_rise)       w_state_nxt = MEAS;
                else if (w_tlast) w_state_nxt = IDLE;
            end
            MEAS:      if (!in) w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_load1  = 1'b0;
        w_inc    = 1'b0;
        w_tclr   = 1'b0;
        w_tinc   = 1'b0;
        w_x_zero = 1'b0;
        w_x_cnt  = 1'b0;
        case (r_state)
            ACK:       w_tclr = ~soc;
            WAIT_RISE: begin
                if (w_rise)       w_load1  = 1'b1;
                else if (w_tlast) w_x_zero = 1'b1;
                else              w_tinc   = 1'b1;
            end
            MEAS: begin
                if (in) w_inc   = 1'b1;
                else    w_x_cnt = 1'b1;
            end
            default: ;
        endcase
    end

    sat_counter #(.W(W)) u_cnt (
        .i_clock   (clock),
        .i_reset_n (reset_),
        .i_load1   (w_load1),
        .i_inc     (w_inc),
        .o_cnt     (w_cnt)
    );

    // eoc is registered from the next state so it never glitches on the decode.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_in_prev <= 1'b0;
            r_eoc     <= 1'b1;
            r_tcnt    <= '0;
            r_x       <= '0;
        end else begin
            r_in_prev <= in;
            r_eoc     <= (w_state_nxt == IDLE);
            if (w_tclr)      r_tcnt <= '0;
            else if (w_tinc) r_tcnt <= r_tcnt + TW'(1);
            if (w_x_zero)     r_x <= '0;
            else if (w_x_cnt) r_x <= w_cnt;
        end
    end

    assign eoc = r_eoc;
    assign x   = r_x;

endmodule

// File: tb/tb_pulse_width_adc.sv
// Scoreboard bench: driver pushes model predictions, monitor checks each eoc rise.
module tb_pulse_width_adc;

    localparam int W    = 8;
    localparam int T    = 20;
    localparam int XMAX = (1 << W) - 1;

    typedef bit bq_t[$];
    typedef struct {
        int x;
        int edge_n;
    } exp_t;

    logic         clock  = 1'b0;
    logic         reset_ = 1'b1;
    logic         soc    = 1'b0;
    logic         in     = 1'b0;
    logic         eoc;
    logic [W-1:0] x;

    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    pulse_width_adc #(.W(W), .TIMEOUT(T)) dut (
        .clock  (clock),
        .reset_ (reset_),
        .soc    (soc),
        .in     (in),
        .eoc    (eoc),
        .x      (x)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // s[0] is `in` as seen on the entry edge; s[k] is `in` at the k-th edge after it.
    function automatic bq_t mk(input int ack, input int hd, input int d, input int w);
        bq_t s;
        s.push_back(bit'(ack));
        repeat (hd) s.push_back(1'b1);
        repeat (d)  s.push_back(1'b0);
        repeat (w)  s.push_back(1'b1);
        s.push_back(1'b0);
        return s;
    endfunction

    // First 0->1 within T edges starts the count; otherwise timeout at edge T with x=0.
    function automatic exp_t model(input bq_t s, input int base);
        exp_t e;
        int   run;
        e.x      = 0;
        e.edge_n = base + T;
        for (int k = 1; k <= T && k < s.size(); k++) begin
            if (s[k] && !s[k-1]) begin
                run = 0;
                while (k + run < s.size() && s[k+run]) run++;
                e.x      = (run > XMAX) ? XMAX : run;
                e.edge_n = base + k + run;
                return e;
            end
        end
        return e;
    endfunction

    task automatic handshake(output bit ok);
        ok  = 1'b0;
        soc = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (!eoc) begin
                ok = 1'b1;
                break;
            end
        end
        check("handshake_ack", int'(ok), 1);
        soc = 1'b0;
    endtask

    task automatic convert(input bq_t s, input bit poke);
        bit ok;
        @(negedge clock);
        in = s[0];
        handshake(ok);
        if (!ok) return;
        sb.push_back(model(s, cyc + 1));
        for (int i = 1; i < s.size(); i++) begin
            @(negedge clock);
            in  = s[i];
            soc = poke && (i == 2);
        end
        @(negedge clock);
        in  = 1'b0;
        soc = 1'b0;
        for (int i = 0; i < T + 400 && !eoc; i++) @(negedge clock);
        check("eoc_return", int'(eoc), 1);
    endtask

    initial begin : monitor
        bit           pe = 1'b1;
        logic [W-1:0] lx = '0;
        exp_t         e;
        forever begin
            @(negedge clock);
            if (!reset_) begin
                pe = 1'b1;
                lx = '0;
            end else begin
                if (eoc && !pe) begin
                    if (sb.size() == 0) begin
                        check("unexpected_eoc", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("x", int'(x), e.x);
                        check("eoc_edge", cyc, e.edge_n);
                        lx = W'(e.x);
                    end
                end else begin
                    check("x_hold", int'(x), int'(lx));
                end
                pe = eoc;
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit ok;
        int ack, hd, d, w;
        #1 reset_ = 1'b0;
        #1;
        check("rst_eoc", int'(eoc), 1);
        check("rst_x", int'(x), 0);
        repeat (2) @(negedge clock);
        #2 reset_ = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("idle_eoc", int'(eoc), 1);
        end

        convert(mk(0, 0, 2, 5), 1'b0);
        convert(mk(0, 0, 0, 300), 1'b0);
        convert(mk(0, 0, 0, 255), 1'b0);
        convert(mk(0, 0, 1, 256), 1'b0);
        convert(mk(0, 0, T + 3, 0), 1'b0);
        convert(mk(0, 0, T - 1, 4), 1'b0);
        convert(mk(0, 0, T, 4), 1'b0);
        convert(mk(1, 3, 2, 3), 1'b0);
        convert(mk(0, 0, 0, 1), 1'b1);

        // Abort a measurement with reset, then prove the next conversion is clean.
        @(negedge clock);
        handshake(ok);
        @(negedge clock);
        in = 1'b1;
        repeat (3) @(negedge clock);
        #2 reset_ = 1'b0;
        #1;
        check("midrst_eoc", int'(eoc), 1);
        check("midrst_x", int'(x), 0);
        @(negedge clock);
        #2;
        reset_ = 1'b1;
        in     = 1'b0;
        convert(mk(0, 0, 1, 7), 1'b0);

        repeat (60) begin
            ack = ($urandom_range(0, 3) == 0) ? 1 : 0;
            hd  = ack ? $urandom_range(0, 3) : 0;
            d   = ($urandom_range(0, 3) == 0) ? $urandom_range(T - 3, T + 1) : $urandom_range(0, 4);
            w   = ($urandom_range(0, 7) == 0) ? $urandom_range(250, 300) : $urandom_range(1, 12);
            convert(mk(ack, hd, d, w), bit'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clock);
        check("sb_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
